uart_xcvr: RTL and testbench



---
 rtl/uart_xcvr_pkg.sv | 34 +++
 rtl/uart_xcvr_fifo.sv | 48 ++++
 rtl/uart_xcvr.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_xcvr_pkg.sv
// Shared types and helpers for the uart_xcvr transceiver.
// Parity states exist only when UART_XCVR_PARITY_EN is defined.
package uart_xcvr_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_XCVR_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_XCVR_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_xcvr_fifo.sv
// Synchronous first-word-fall-through FIFO for the uart_xcvr RX path.
// Simultaneous push and pop are both honoured, including when full.
module uart_xcvr_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           resetb,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;
  assign level    = LW'(wr_ptr - rd_ptr);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver with RX FIFO, mid-bit sampling and sticky error flags.
// Optional parity bit in both directions via `define UART_XCVR_PARITY_EN.
module uart_xcvr
  import uart_xcvr_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4167,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                              clock,
  input  logic                              resetb,
  input  logic                              tx_start,
  input  logic [DATA_W-1:0]                 tx_data,
  output logic                              tx_busy,
  output logic                              tx_clear_req,
  output logic                              ser_tx,
  input  logic                              ser_rx,
  output logic                              rx_valid,
  output logic [DATA_W-1:0]                 rx_data,
  input  logic                              rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level,
  output logic                              rx_overrun,
  output logic                              rx_frame_err,
  output logic                              rx_parity_err,
  input  logic                              err_clear
);

  localparam int unsigned HALF_BIT = half_bit(CLKS_PER_BIT);
  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_PRE   = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 4 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_xcvr: illegal parameter combination");
  end

  // ---------------- transmitter ----------------
  tx_state_t         tx_state;
  logic [CW-1:0]     tx_cnt;
  logic [DATA_W-1:0] tx_shreg;
  logic [3:0]        tx_bit;
  logic              tx_stop_idx;
`ifdef UART_XCVR_PARITY_EN
  logic              tx_par;
`endif

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_shreg     <= '0;
      tx_bit       <= '0;
      tx_stop_idx  <= 1'b0;
      ser_tx       <= 1'b1;
      tx_busy      <= 1'b0;
      tx_clear_req <= 1'b0;
`ifdef UART_XCVR_PARITY_EN
      tx_par       <= 1'b0;
`endif
    end else begin
      tx_clear_req <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          ser_tx  <= 1'b1;
          tx_busy <= 1'b0;
          tx_cnt  <= '0;
          if (tx_start) begin
            tx_shreg <= tx_data;
`ifdef UART_XCVR_PARITY_EN
            tx_par   <= parity_bit(9'(tx_data), 1'(PARITY_ODD));
`endif
            ser_tx   <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= TX_START;
          end
        end
        default: begin
          // Registered pulse lands in the final cycle of the last stop bit.
          tx_clear_req <= (tx_state == TX_STOP) && (tx_cnt == BIT_PRE) && (tx_stop_idx == STOP_LAST);
          if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt <= '0;
            case (tx_state)
              TX_START: begin
                tx_state <= TX_DATA;
                tx_bit   <= '0;
                ser_tx   <= tx_shreg[0];
              end
              TX_DATA: begin
                if (tx_bit == DATA_LAST) begin
`ifdef UART_XCVR_PARITY_EN
                  tx_state <= TX_PARITY;
                  ser_tx   <= tx_par;
`else
                  tx_state    <= TX_STOP;
                  tx_stop_idx <= 1'b0;
                  ser_tx      <= 1'b1;
`endif
                end else begin
                  tx_bit   <= tx_bit + 1'b1;
                  tx_shreg <= tx_shreg >> 1;
                  ser_tx   <= tx_shreg[1];
                end
              end
`ifdef UART_XCVR_PARITY_EN
              TX_PARITY: begin
                tx_state    <= TX_STOP;
                tx_stop_idx <= 1'b0;
                ser_tx      <= 1'b1;
              end
`endif
              TX_STOP: begin
                if (tx_stop_idx == STOP_LAST) begin
                  tx_state <= TX_IDLE;
                  tx_busy  <= 1'b0;
                  ser_tx   <= 1'b1;
                end else begin
                  tx_stop_idx <= 1'b1;
                end
              end
              default: tx_state <= TX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_s1;
  logic rx_s2;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= ser_rx;
      rx_s2 <= rx_s1;
    end
  end

  rx_state_t         rx_state;
  logic [CW-1:0]     rx_cnt;
  logic [DATA_W-1:0] rx_shreg;
  logic [3:0]        rx_bit;
  logic              rx_wait_high;
  logic              rx_sample;

  assign rx_sample = (rx_cnt == BIT_LAST);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_shreg     <= '0;
      rx_bit       <= '0;
      rx_wait_high <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          // After a framing error the line must go high before a new start is accepted.
          if (rx_wait_high) begin
            if (rx_s2) rx_wait_high <= 1'b0;
          end else if (!rx_s2) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_s2, rx_shreg[DATA_W-1:1]};
            if (rx_bit == DATA_LAST) begin
`ifdef UART_XCVR_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_XCVR_PARITY_EN
        RX_PARITY: begin
          if (rx_sample) begin
            rx_cnt   <= '0;
            rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (rx_sample) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (!rx_s2) rx_wait_high <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- FIFO and flags ----------------
  logic rx_push;
  logic rx_pop;
  logic fifo_full;
  logic fifo_empty;
  logic overrun_evt;
  logic frame_evt;

  always_comb begin
    rx_push     = 1'b0;
    frame_evt   = 1'b0;
    if (rx_state == RX_STOP && rx_sample) begin
      rx_push   = rx_s2;
      frame_evt = !rx_s2;
    end
    rx_pop      = rx_valid && rx_ready;
    overrun_evt = rx_push && fifo_full && !rx_pop;
  end

  assign rx_valid = !fifo_empty;

  uart_xcvr_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetb    (resetb),
    .push      (rx_push),
    .push_data (rx_shreg),
    .pop       (rx_pop),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (rx_level)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (err_clear) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      if (overrun_evt) rx_overrun   <= 1'b1;
      if (frame_evt)   rx_frame_err <= 1'b1;
    end
  end

`ifdef UART_XCVR_PARITY_EN
  logic parity_evt;

  always_comb begin
    parity_evt = 1'b0;
    if (rx_state == RX_PARITY && rx_sample)
      parity_evt = (rx_s2 != parity_bit(9'(rx_shreg), 1'(PARITY_ODD)));
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_parity_err <= 1'b0;
    end else begin
      if (err_clear)  rx_parity_err <= 1'b0;
      if (parity_evt) rx_parity_err <= 1'b1;
    end
  end
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// Scoreboard bench for uart_xcvr: directed TX/RX frames, overrun, glitch, framing error, reset.
module tb_uart_xcvr;

  localparam int CPB = 16;
  localparam int DW  = 8;
`ifdef UART_XCVR_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (1 + DW + P + 1) * CPB;

  logic          clock;
  logic          resetb;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic          tx_clear_req;
  logic          ser_tx;
  logic          ser_rx;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_ready;
  logic [2:0]    rx_level;
  logic          rx_overrun;
  logic          rx_frame_err;
  logic          rx_parity_err;
  logic          err_clear;
  logic          loopback;
  logic          rx_drv;

  assign ser_rx = loopback ? ser_tx : rx_drv;

  uart_xcvr #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (4),
    .PARITY_ODD   (0)
  ) dut (
    .clock         (clock),
    .resetb        (resetb),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_busy       (tx_busy),
    .tx_clear_req  (tx_clear_req),
    .ser_tx        (ser_tx),
    .ser_rx        (ser_rx),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .rx_level      (rx_level),
    .rx_overrun    (rx_overrun),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .err_clear     (err_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every word the DUT hands over is compared with the oldest expected word.
  always @(negedge clock) begin
    if (resetb && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected_word: got 0x%0h, expected no word", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rx_word", 32'(rx_data), 32'(mon_exp));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_tx(input logic [DW-1:0] d);
    int k;
    tx_data  = d;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    k = 0;
    while (tx_busy && k < FRAME + 20) begin
      tick(1);
      k++;
    end
    check("tx_done_timeout", 32'(tx_busy), 32'd0);
  endtask

  task automatic inject(input logic [DW-1:0] d, input logic stop, input logic par_good);
    rx_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < DW; i++) begin
      rx_drv = d[i];
      tick(CPB);
    end
`ifdef UART_XCVR_PARITY_EN
    rx_drv = par_good ? (^d) : ~(^d);
    tick(CPB);
`else
    if (par_good) rx_drv = 1'b1;
`endif
    rx_drv = stop;
    tick(CPB);
    rx_drv = 1'b1;
    tick(3);
  endtask

  task automatic drain();
    int k;
    rx_ready = 1'b1;
    k = 0;
    while (rx_level != 0 && k < 20) begin
      tick(1);
      k++;
    end
    rx_ready = 1'b0;
    check("drain_level", 32'(rx_level), 32'd0);
  endtask

  logic rec_tx   [FRAME + 40];
  logic rec_busy [FRAME + 40];
  logic rec_clr  [FRAME + 40];
  logic [9:0] pat;

  initial begin
    int busy_cnt;
    int clr_cnt;
    int clr_idx;
    resetb    = 1'b0;
    tx_start  = 1'b0;
    tx_data   = '0;
    rx_ready  = 1'b0;
    err_clear = 1'b0;
    loopback  = 1'b0;
    rx_drv    = 1'b1;
    tick(3);
    check("rst_ser_tx", 32'(ser_tx), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_tx_clear_req", 32'(tx_clear_req), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_level", 32'(rx_level), 32'd0);
    check("rst_flags", {29'd0, rx_overrun, rx_frame_err, rx_parity_err}, 32'd0);
    resetb = 1'b1;
    tick(2);

    // TX frame 0x3D: start, 1,0,1,1,1,1,0,0, then parity (if any, =1) or stop.
    pat      = 10'b1001111010;
    tx_data  = 8'h3D;
    tx_start = 1'b1;
    for (int i = 0; i < FRAME + 40; i++) begin
      tick(1);
      if (i == 0) tx_start = 1'b0;
      rec_tx[i]   = ser_tx;
      rec_busy[i] = tx_busy;
      rec_clr[i]  = tx_clear_req;
    end
    busy_cnt = 0;
    clr_cnt  = 0;
    clr_idx  = -1;
    for (int i = 0; i < FRAME + 40; i++) begin
      if (rec_busy[i]) busy_cnt++;
      if (rec_clr[i]) begin
        clr_cnt++;
        clr_idx = i;
      end
    end
    check("tx_start_latency_busy", 32'(rec_busy[0]), 32'd1);
    check("tx_start_latency_low", 32'(rec_tx[0]), 32'd0);
    check("tx_busy_cycles", 32'(busy_cnt), 32'(FRAME));
    check("tx_clear_req_count", 32'(clr_cnt), 32'd1);
    check("tx_clear_req_pos", 32'(clr_idx), 32'(FRAME - 1));
    check("tx_busy_fall", 32'(rec_busy[FRAME]), 32'd0);
    for (int k = 0; k < 10; k++)
      check($sformatf("tx_bit%0d", k), 32'(rec_tx[k * CPB + CPB / 2]), 32'(pat[k]));

    // Loopback of two words with the FIFO held.
    loopback = 1'b1;
    tick(2);
    exp_q.push_back(8'h0F);
    send_tx(8'h0F);
    exp_q.push_back(8'hAB);
    send_tx(8'hAB);
    tick(4);
    check("loop_level", 32'(rx_level), 32'd2);
    check("loop_head", 32'(rx_data), 32'h0F);
    drain();
    loopback = 1'b0;
    tick(4);

    // Overrun: five frames into a four-deep FIFO.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'(8'h11 * (i + 1)));
      inject(8'(8'h11 * (i + 1)), 1'b1, 1'b1);
    end
    check("ovr_level", 32'(rx_level), 32'd4);
    check("ovr_flag", 32'(rx_overrun), 32'd1);
    check("ovr_head", 32'(rx_data), 32'h11);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("ovr_cleared", 32'(rx_overrun), 32'd0);
    drain();

    // Short glitch must be rejected as a false start.
    rx_drv = 1'b0;
    tick(5);
    rx_drv = 1'b1;
    tick(40);
    check("glitch_level", 32'(rx_level), 32'd0);
    check("glitch_frame_err", 32'(rx_frame_err), 32'd0);
    check("glitch_valid", 32'(rx_valid), 32'd0);

    // Framing error: low stop bit discards the word.
    inject(8'h5A, 1'b0, 1'b1);
    check("ferr_flag", 32'(rx_frame_err), 32'd1);
    check("ferr_level", 32'(rx_level), 32'd0);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("ferr_cleared", 32'(rx_frame_err), 32'd0);
    exp_q.push_back(8'hC6);
    inject(8'hC6, 1'b1, 1'b1);
    check("ferr_recover_level", 32'(rx_level), 32'd1);
    drain();

`ifdef UART_XCVR_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit is 1.
    tx_data  = 8'h07;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tick(9 * CPB + CPB / 2);
    check("tx_parity_bit", 32'(ser_tx), 32'd1);
    tick(2 * CPB);
    exp_q.push_back(8'h07);
    inject(8'h07, 1'b1, 1'b0);
    check("par_err_flag", 32'(rx_parity_err), 32'd1);
    check("par_err_level", 32'(rx_level), 32'd1);
    drain();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("par_err_cleared", 32'(rx_parity_err), 32'd0);
`endif

    // Reset during TX data bit 3 with two words queued.
    inject(8'h96, 1'b1, 1'b1);
    inject(8'h69, 1'b1, 1'b1);
    check("pre_rst_level", 32'(rx_level), 32'd2);
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tick(4 * CPB + 6);
    check("pre_rst_ser_tx", 32'(ser_tx), 32'd0);
    check("pre_rst_busy", 32'(tx_busy), 32'd1);
    resetb = 1'b0;
    #1;
    check("mid_rst_ser_tx", 32'(ser_tx), 32'd1);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_level", 32'(rx_level), 32'd0);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    tick(2);
    resetb = 1'b1;
    tick(4);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
